// File: rtl/reg_file_if.sv
// Register-file access bundle: two ID read ports, the WB write port and the debug/commit taps.
// No backpressure anywhere; the master drives requests and the slave answers.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [DATA_WIDTH-1:0] debug_data;
  logic [31:0]           commit_count;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    output write_en, write_addr, write_data, debug_addr,
    input  read_data_1, read_data_2, debug_data, commit_count
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  write_en, write_addr, write_data, debug_addr,
    output read_data_1, read_data_2, debug_data, commit_count
  );
endinterface

// File: rtl/reg_file.sv
// CPU register file: 2 combinational read ports with same-cycle write bypass, 1 write port, r0 hardwired to 0.
// Reads 0 cycles, writes land at the next rising edge; no backpressure, every request is served.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave rf
);

  if (REG_NUM != 2**ADDR_WIDTH) begin : g_bad_params
    $error("reg_file: REG_NUM must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] regs [1:REG_NUM-1];
  logic [31:0]           commit_count_q;
  logic                  write_ok;

  assign write_ok = rf.write_en && (rf.write_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
      commit_count_q <= '0;
    end else if (write_ok) begin
      regs[rf.write_addr] <= rf.write_data;
      commit_count_q      <= commit_count_q + 32'd1;
    end
  end

  // Each port applies the bypass on its own, so both may hit the register being written.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (rst || !en || addr == '0) begin
      val = '0;
    end else if (rf.write_en && rf.write_addr == addr) begin
      val = rf.write_data;
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    rf.read_data_1 = read_port(rf.read_en_1, rf.read_addr_1);
    rf.read_data_2 = read_port(rf.read_en_2, rf.read_addr_2);
  end

  // Debug sees storage only, so a write shows up here one cycle after its edge.
  always_comb begin
    rf.debug_data = '0;
    if (!rst && rf.debug_addr != '0) begin
      rf.debug_data = regs[rf.debug_addr];
    end
  end

  assign rf.commit_count = commit_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, bypass, r0, read enables, reset collision.
module tb_reg_file;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
    rf_if.write_en   = en;
    rf_if.write_addr = addr;
    rf_if.write_data = data;
  endtask

  task automatic set_reads(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                           input logic [4:0] dbg);
    rf_if.read_en_1   = e1;
    rf_if.read_addr_1 = a1;
    rf_if.read_en_2   = e2;
    rf_if.read_addr_2 = a2;
    rf_if.debug_addr  = dbg;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd5, 1'b1, 5'd31, 5'd5);

    // Reset held for two cycles; outputs forced to zero while asserted
    tick();
    tick();
    #1;
    check("rst_rd1_forced", rf_if.read_data_1, 32'h0);
    check("rst_dbg_forced", rf_if.debug_data, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_rd1_r5", rf_if.read_data_1, 32'h0);
    check("post_rst_rd2_r31", rf_if.read_data_2, 32'h0);
    check("post_rst_count", rf_if.commit_count, 32'd0);

    // Basic write r8, read next cycle
    set_write(1'b1, 5'd8, 32'h1234_5678);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd8, 1'b1, 5'd8, 5'd8);
    #1;
    check("r8_rd1", rf_if.read_data_1, 32'h1234_5678);
    check("r8_rd2", rf_if.read_data_2, 32'h1234_5678);
    check("r8_dbg", rf_if.debug_data, 32'h1234_5678);
    check("r8_count", rf_if.commit_count, 32'd1);

    // Bypass on both ports; debug still shows stored value
    set_write(1'b1, 5'd9, 32'hDEAD_BEEF);
    set_reads(1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
    #1;
    check("byp_rd1", rf_if.read_data_1, 32'hDEAD_BEEF);
    check("byp_rd2", rf_if.read_data_2, 32'hDEAD_BEEF);
    check("byp_dbg_old", rf_if.debug_data, 32'h0);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("byp_dbg_new", rf_if.debug_data, 32'hDEAD_BEEF);
    check("byp_rd1_stored", rf_if.read_data_1, 32'hDEAD_BEEF);
    check("byp_count", rf_if.commit_count, 32'd2);

    // Write to r0 is dropped
    set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_reads(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #1;
    check("r0_rd1_same", rf_if.read_data_1, 32'h0);
    check("r0_rd2_same", rf_if.read_data_2, 32'h0);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_dbg", rf_if.debug_data, 32'h0);
    check("r0_rd1_after", rf_if.read_data_1, 32'h0);
    check("r0_count", rf_if.commit_count, 32'd2);

    // Read enables gate the output, including over a bypass hit
    set_write(1'b1, 5'd3, 32'h0000_0055);
    set_reads(1'b0, 5'd3, 1'b1, 5'd3, 5'd3);
    #1;
    check("dis_rd1_bypass", rf_if.read_data_1, 32'h0);
    check("en_rd2_bypass", rf_if.read_data_2, 32'h0000_0055);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd8, 1'b0, 5'd3, 5'd3);
    #1;
    check("dis_rd2", rf_if.read_data_2, 32'h0);
    check("other_rd1_r8", rf_if.read_data_1, 32'h1234_5678);
    rf_if.read_en_2 = 1'b1;
    #1;
    check("en_rd2", rf_if.read_data_2, 32'h0000_0055);
    check("r3_count", rf_if.commit_count, 32'd3);

    // Top register address
    set_write(1'b1, 5'd31, 32'hA5A5_A5A5);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd31, 1'b1, 5'd9, 5'd31);
    #1;
    check("r31_rd1", rf_if.read_data_1, 32'hA5A5_A5A5);
    check("r31_dbg", rf_if.debug_data, 32'hA5A5_A5A5);
    check("r31_rd2_r9", rf_if.read_data_2, 32'hDEAD_BEEF);
    check("r31_count", rf_if.commit_count, 32'd4);

    // Reset collides with a write to r4
    set_write(1'b1, 5'd4, 32'h0000_0077);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
    #1;
    check("r4_pre", rf_if.read_data_1, 32'h0000_0077);
    check("r4_pre_count", rf_if.commit_count, 32'd5);
    rst = 1'b1;
    set_write(1'b1, 5'd4, 32'h0000_0099);
    #1;
    check("coll_rd1_forced", rf_if.read_data_1, 32'h0);
    check("coll_rd2_forced", rf_if.read_data_2, 32'h0);
    tick();
    rst = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("coll_r4_rd1", rf_if.read_data_1, 32'h0);
    check("coll_r4_dbg", rf_if.debug_data, 32'h0);
    check("coll_count", rf_if.commit_count, 32'd0);
    rf_if.debug_addr = 5'd8;
    #1;
    check("coll_r8_cleared", rf_if.debug_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file of the CPU core. It answers the two read requests issued each cycle by the ID-stage decoders (read enable plus address, values returned combinationally) and commits the single write coming back from the WB stage.
- Provides write-to-read bypass so that a value written in the current cycle is seen by ID in the same cycle.
- Keeps $zero hardwired to 0.
- Exposes a debug read port and a commit counter for the difftest/verification harness.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register address width.
- REG_NUM, 32, number of architectural registers. Must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset (RST_ENABLE = 1).
- read_en_1  input  1  read port 1 enable from ID.
- read_addr_1  input  ADDR_WIDTH  read port 1 register address.
- read_data_1  output  DATA_WIDTH  read port 1 value; combinational.
- read_en_2  input  1  read port 2 enable from ID.
- read_addr_2  input  ADDR_WIDTH  read port 2 register address.
- read_data_2  output  DATA_WIDTH  read port 2 value; combinational.
- write_en  input  1  write enable from WB.
- write_addr  input  ADDR_WIDTH  destination register.
- write_data  input  DATA_WIDTH  value to commit.
- debug_addr  input  ADDR_WIDTH  debug read address; no bypass.
- debug_data  output  DATA_WIDTH  stored value at debug_addr.
- commit_count  output  32  number of committed writes to non-zero registers.

Behaviour:
- Storage: registers 1..REG_NUM-1, DATA_WIDTH bits each. Register 0 is never stored and always reads 0.
- Reset: while rst=1 at a rising edge, all registers and commit_count clear to 0. While rst=1, read_data_1, read_data_2 and debug_data are forced to 0 combinationally. Any write_en asserted in a reset cycle is discarded and not counted.
- Write: at a rising edge with rst=0, write_en=1 and write_addr!=0, the register at write_addr takes write_data, and commit_count increments by 1. commit_count wraps from 0xFFFFFFFF to 0. A write with write_addr=0 is dropped and not counted.
- Read port n (n=1,2), combinational, priority order:
  - rst=1 → 0.
  - read_en_n=0 → 0.
  - read_addr_n=0 → 0.
  - write_en=1 and write_addr==read_addr_n → write_data (same-cycle bypass).
  - otherwise → stored register value.
- Both read ports may address the same register, including the one being written; each port applies the bypass independently.
- Debug port: returns the stored value only, with no bypass. It reflects a write one cycle after the write edge. debug_addr=0 → 0.
- Latency: reads 0 cycles. A write is visible via the bypass in its own cycle and via storage from the next cycle.
- Reset mid-operation: a write pending in the same cycle as reset is lost. The first post-reset read of any register returns 0.
- No X propagation: all outputs are defined for all input combinations after the first reset.

Test Plan:
- Reset then reads: assert rst for 2 cycles, then read_en_1=read_en_2=1 on addresses 5 and 31 → read_data_1=read_data_2=0, commit_count=0.
- Basic write/read: write 0x1234_5678 to r8, next cycle read r8 on both ports → both 0x1234_5678, debug_data(8)=0x1234_5678, commit_count=1.
- Bypass: in one cycle, write_en=1 to r9 with 0xDEAD_BEEF and read_addr_1=9 → read_data_1=0xDEAD_BEEF in the same cycle, while debug_data(9) still shows the old value (0); debug_data(9)=0xDEAD_BEEF after the edge.
- Zero register: write 0xFFFF_FFFF to r0 → reading r0 on ports 1, 2 and debug gives 0, and commit_count is unchanged.
- Read disable: r3=0x55, read_en_2=0 with read_addr_2=3 → read_data_2=0. Set read_en_2=1 → read_data_2=0x55.
- Reset collision: r4=0x77, then one cycle with rst=1 and write_en=1 to r4 with 0x99 → after reset, read r4=0 and commit_count=0.
